// File: rtl/dtb_pkg.sv
// rtl/dtb_pkg.sv - shared defaults and types for the stream trace buffer readout path
package dtb_pkg;
  localparam int TRB_WIDTH      = 32;
  localparam int TRB_MAX_TRACES = 8;
  localparam int TRB_NT_BITS    = $clog2($clog2(TRB_MAX_TRACES) + 1);

  typedef logic [TRB_NT_BITS-1:0] num_traces_t;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;
endpackage

// File: rtl/stb_word_skid.sv
// rtl/stb_word_skid.sv - one-entry word holding slot with registered ready
// STB_SER_TRIG_EN adds a stored trigger flag alongside the word.
module stb_word_skid
  import dtb_pkg::*;
#(
  parameter int WIDTH = TRB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_trig,
  input  logic             i_pop,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data,
  output logic             o_trig
);
  logic             r_full;
  logic             r_ready;
  logic [WIDTH-1:0] r_data;
  logic             w_push;

  // Ready is only high while empty, so push and pop never coincide.
  assign w_push = i_valid && r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full  <= 1'b0;
      r_ready <= 1'b1;
      r_data  <= '0;
    end else if (w_push) begin
      r_full  <= 1'b1;
      r_ready <= 1'b0;
      r_data  <= i_data;
    end else if (i_pop) begin
      r_full  <= 1'b0;
      r_ready <= 1'b1;
    end
  end

  assign o_ready = r_ready;
  assign o_full  = r_full;
  assign o_data  = r_data;

`ifdef STB_SER_TRIG_EN
  logic r_trig;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_trig <= 1'b0;
    end else if (w_push) begin
      r_trig <= i_trig;
    end
  end

  assign o_trig = r_trig;
`else
  logic w_unused_trig;
  assign w_unused_trig = i_trig;
  assign o_trig        = 1'b0;
`endif
endmodule

// File: rtl/trace_stream_serializer.sv
// rtl/trace_stream_serializer.sv - shifts buffered trace words onto 2**NUM_TRACES_I lanes
// STB_SER_TRIG_EN enables the per-word trigger mark on TRIG_O.
module trace_stream_serializer
  import dtb_pkg::*;
#(
  parameter int WIDTH      = TRB_WIDTH,
  parameter int MAX_TRACES = TRB_MAX_TRACES,
  parameter int NT_BITS    = TRB_NT_BITS
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  DATA_VALID_I,
  output logic                  DATA_READY_O,
  input  logic [WIDTH-1:0]      DATA_I,
  input  logic                  TRIG_I,
  input  logic [NT_BITS-1:0]    NUM_TRACES_I,
  input  logic                  READ_I,
  output logic [MAX_TRACES-1:0] STREAM_O,
  output logic                  STREAM_VALID_O,
  output logic                  TRIG_O,
  output logic                  UNDERRUN_O
);
  localparam int LOG2_MAX = $clog2(MAX_TRACES);
  localparam int CNT_W    = $clog2(WIDTH) + 1;
  localparam int LANE_W   = LOG2_MAX + 1;

  ser_state_t         r_state;
  ser_state_t         w_state_d;
  logic [WIDTH-1:0]   r_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic [NT_BITS-1:0] r_nt;
  logic [NT_BITS-1:0] w_nt_sat;
  logic               r_underrun;
  logic               w_skid_full;
  logic [WIDTH-1:0]   w_skid_data;
  logic               w_skid_trig;
  logic               w_load;
  logic               w_shift;
  logic               w_last;
  logic               w_valid;
  logic [LANE_W-1:0]  w_lanes;

  stb_word_skid #(.WIDTH(WIDTH)) u_skid (
    .clk     (CLK_I),
    .rst     (RST_I),
    .i_valid (DATA_VALID_I),
    .o_ready (DATA_READY_O),
    .i_data  (DATA_I),
    .i_trig  (TRIG_I),
    .i_pop   (w_load),
    .o_full  (w_skid_full),
    .o_data  (w_skid_data),
    .o_trig  (w_skid_trig)
  );

  assign w_valid  = (r_state == SER_SHIFT);
  assign w_lanes  = LANE_W'(1) << r_nt;
  assign w_last   = (r_cnt == CNT_W'((WIDTH >> r_nt) - 1));
  assign w_nt_sat = (int'(NUM_TRACES_I) > LOG2_MAX) ? NT_BITS'(LOG2_MAX) : NUM_TRACES_I;

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    case (r_state)
      SER_IDLE: begin
        if (w_skid_full) begin
          w_load    = 1'b1;
          w_state_d = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        // A word arriving on the last beat lands in the slot first, hence one bubble.
        if (READ_I) begin
          if (!w_last) begin
            w_shift = 1'b1;
          end else if (w_skid_full) begin
            w_load = 1'b1;
          end else begin
            w_state_d = SER_IDLE;
          end
        end
      end
      default: w_state_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state    <= SER_IDLE;
      r_sr       <= '0;
      r_cnt      <= '0;
      r_nt       <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_load) begin
        r_sr  <= w_skid_data;
        r_cnt <= '0;
        r_nt  <= w_nt_sat;
      end else if (w_shift) begin
        r_sr  <= r_sr >> w_lanes;
        r_cnt <= r_cnt + 1'b1;
      end
      if (READ_I && !w_valid) begin
        r_underrun <= 1'b1;
      end
    end
  end

  always_comb begin
    STREAM_O = '0;
    for (int j = 0; j < MAX_TRACES; j++) begin
      if (w_valid && (LANE_W'(j) < w_lanes)) begin
        STREAM_O[j] = r_sr[j];
      end
    end
  end

  assign STREAM_VALID_O = w_valid;
  assign UNDERRUN_O     = r_underrun;

`ifdef STB_SER_TRIG_EN
  logic r_trig;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_trig <= 1'b0;
    end else if (w_load) begin
      r_trig <= w_skid_trig;
    end
  end

  assign TRIG_O = r_trig && (r_cnt == '0) && w_valid;
`else
  logic w_unused_skid_trig;
  assign w_unused_skid_trig = w_skid_trig;
  assign TRIG_O             = 1'b0;
`endif
endmodule
